pe_conv_seq: RTL

PE_CONV_SEQ -- requirements
Module: pe_conv_seq

---
 rtl/pe_pkg.sv | 29 ++
 rtl/pe_mac.sv | 39 +++
 rtl/pe_conv_seq.sv | 112 +++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared constants, FSM encoding and tap addressing for pe_conv_seq
package pe_pkg;

  localparam int DATA_W   = 8;
  localparam int PROD_W   = 2 * DATA_W;
  localparam int ACC_W    = 20;
  localparam int MAC_TAPS = 9;
  localparam int N_OUT    = 4;
  localparam int TAP_W    = 4;
  localparam int OUT_W    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    WRITE = 2'd2,
    FIN   = 2'd3
  } pe_state_t;

  // Element index (row*4 + col) of the 4x4 input feeding tap k,l of output out_idx.
  function automatic logic [3:0] a_index(input logic [OUT_W-1:0] out_idx,
                                         input logic [TAP_W-1:0] tap);
    logic [1:0] k;
    logic [1:0] l;
    k = 2'(tap / 4'd3);
    l = 2'(tap % 4'd3);
    a_index = {2'(k + {1'b0, out_idx[1]}), 2'(l + {1'b0, out_idx[0]})};
  endfunction

endpackage

// File: rtl/pe_mac.sv
// rtl/pe_mac.sv - 8x8 multiply with 20-bit accumulator and output byte formatting
// Optional feature: PE_SAT_EN saturates the output byte instead of wrapping.
module pe_mac
  import pe_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_next;

  assign prod     = PROD_W'(a) * PROD_W'(b);
  assign acc_next = acc + ACC_W'(prod);

  // result reflects the sum including the current tap, so it is ready on the final tap edge
`ifdef PE_SAT_EN
  assign result = (|acc_next[ACC_W-1:DATA_W]) ? {DATA_W{1'b1}} : acc_next[DATA_W-1:0];
`else
  assign result = acc_next[DATA_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/pe_conv_seq.sv
// rtl/pe_conv_seq.sv - sequential 4x4 by 3x3 valid convolution, one tap per cycle
// Optional feature: PE_SAT_EN (handled in pe_mac) saturates PE_result at 8'hFF.
module pe_conv_seq
  import pe_pkg::*;
(
  input  logic         clk,
  input  logic         rst_pe_n,
  input  logic         start,
  input  logic [127:0] a_flat,
  input  logic [71:0]  b_flat,
  output logic [7:0]   PE_result,
  output logic         C11_PE,
  output logic         C12_PE,
  output logic         C21_PE,
  output logic         C22_PE,
  output logic         busy,
  output logic         done
);

  pe_state_t         state, state_next;
  logic [127:0]      a_q;
  logic [71:0]       b_q;
  logic [TAP_W-1:0]  tap;
  logic [OUT_W-1:0]  out_idx;
  logic              accept, mac_clr, mac_en;
  logic              last_tap, last_out, wr;
  logic [DATA_W-1:0] a_sel, b_sel, mac_result;

  assign last_tap = (tap == TAP_W'(MAC_TAPS - 1));
  assign last_out = (out_idx == OUT_W'(N_OUT - 1));
  assign wr       = (state == MAC) && last_tap;
  assign a_sel    = a_q[{a_index(out_idx, tap), 3'b000} +: DATA_W];
  assign b_sel    = b_q[{tap, 3'b000} +: DATA_W];

  pe_mac u_mac (
    .clk    (clk),
    .rst_n  (rst_pe_n),
    .clr    (mac_clr),
    .en     (mac_en),
    .a      (a_sel),
    .b      (b_sel),
    .result (mac_result)
  );

  always_ff @(posedge clk or negedge rst_pe_n) begin
    if (!rst_pe_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    mac_clr    = 1'b0;
    mac_en     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = MAC;
          accept     = 1'b1;
          mac_clr    = 1'b1;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (last_tap) state_next = WRITE;
      end
      WRITE: begin
        mac_clr    = 1'b1;
        state_next = last_out ? FIN : MAC;
      end
      FIN: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes and PE_result are set on the edge entering WRITE, so they cover exactly that cycle.
  always_ff @(posedge clk or negedge rst_pe_n) begin
    if (!rst_pe_n) begin
      PE_result <= '0;
      C11_PE    <= 1'b0;
      C12_PE    <= 1'b0;
      C21_PE    <= 1'b0;
      C22_PE    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      tap       <= '0;
      out_idx   <= '0;
    end else begin
      busy   <= (state_next != IDLE);
      done   <= (state == WRITE) && last_out;
      C11_PE <= wr && (out_idx == 2'd0);
      C12_PE <= wr && (out_idx == 2'd1);
      C21_PE <= wr && (out_idx == 2'd2);
      C22_PE <= wr && (out_idx == 2'd3);
      if (wr) PE_result <= mac_result;
      tap <= ((state == MAC) && !last_tap) ? tap + TAP_W'(1) : '0;
      if (accept) begin
        a_q     <= a_flat;
        b_q     <= b_flat;
        out_idx <= '0;
      end else if (state == WRITE) begin
        out_idx <= out_idx + OUT_W'(1);
      end
    end
  end

endmodule
